// File: rtl/tone_pkg.sv
// Shared definitions for the tone oscillator bank: note codes, the note
// frequency table, channel states and the half-period calculation.
package tone_pkg;

  localparam int unsigned N_NOTES = 14;

  // Codes 14 and 15 are both rests; only 15 has a name.
  typedef enum logic [3:0] {
    NOTE_AS3  = 4'd0,
    NOTE_B3,
    NOTE_C4,
    NOTE_D4,
    NOTE_E4,
    NOTE_F4,
    NOTE_G4,
    NOTE_A4,
    NOTE_B4,
    NOTE_C5,
    NOTE_D5,
    NOTE_E5,
    NOTE_F5,
    NOTE_G5,
    NOTE_REST = 4'd15
  } note_e;

  localparam int unsigned NOTE_FREQ [N_NOTES] = '{
    233, 247, 262, 294, 330, 349, 392, 440, 494, 523, 587, 659, 698, 784
  };

  typedef enum logic [1:0] {IDLE, RUN, REST} osc_state_e;

  function automatic logic note_valid(input logic [3:0] code);
    return code < 4'(N_NOTES);
  endfunction

  // One constant division per table entry, so a fixed clock_speed folds to a
  // small constant mux rather than a real divider.
  function automatic logic [31:0] half_period(input logic [3:0] code,
                                              input logic [1:0] oct,
                                              input int unsigned clock_speed);
    logic [31:0] base;
    logic [31:0] hp;
    base = '0;
    for (int i = 0; i < N_NOTES; i++) begin
      if (code == 4'(i)) base = (clock_speed / NOTE_FREQ[i]) >> 1;
    end
    hp = base >> oct;
    if (hp == '0) hp = 32'd1;
    return hp;
  endfunction

endpackage

// File: rtl/tone_osc_ch.sv
// One square-wave oscillator channel: IDLE/RUN/REST state machine plus a
// half-period down-counter; note changes land only on half-period boundaries.
module tone_osc_ch
  import tone_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED = 25_000_000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [3:0] tone_i,
  input  logic [1:0] oct_i,
  output logic       wave_o,
  output logic       edge_o
);

  osc_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] reload;
  logic             wave_q, wave_d;
  logic             edge_q, edge_d;
  logic [3:0]       tone_q, tone_d;
  logic [1:0]       oct_q, oct_d;
  logic             tone_ok;
  logic             unused_active;

  assign tone_ok = note_valid(tone_i);
  assign reload  = CNT_W'(half_period(tone_i, oct_i, CLOCK_SPEED)) - CNT_W'(1);

  // The latched note is channel state kept for debug visibility only.
  assign unused_active = ^{tone_q, oct_q};

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    wave_d  = wave_q;
    tone_d  = tone_q;
    oct_d   = oct_q;

    if (!en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      wave_d  = 1'b0;
      tone_d  = NOTE_REST;
      oct_d   = '0;
    end else begin
      case (state_q)
        IDLE, REST: begin
          if (tone_ok) begin
            state_d = RUN;
            cnt_d   = reload;
            wave_d  = 1'b0;
            tone_d  = tone_i;
            oct_d   = oct_i;
          end else begin
            state_d = REST;
            cnt_d   = '0;
            wave_d  = 1'b0;
          end
        end
        RUN: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (tone_ok) begin
            wave_d = ~wave_q;
            cnt_d  = reload;
            tone_d = tone_i;
            oct_d  = oct_i;
          end else begin
            state_d = REST;
            cnt_d   = '0;
            wave_d  = 1'b0;
            tone_d  = NOTE_REST;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          wave_d  = 1'b0;
        end
      endcase
    end

    edge_d = wave_d & ~wave_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wave_q  <= 1'b0;
      edge_q  <= 1'b0;
      tone_q  <= NOTE_REST;
      oct_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wave_q  <= wave_d;
      edge_q  <= edge_d;
      tone_q  <= tone_d;
      oct_q   <= oct_d;
    end
  end

  assign wave_o = wave_q;
  assign edge_o = edge_q;

endmodule

// File: rtl/tone_osc_bank.sv
// Bank of independent square-wave tone channels with a registered mix level
// (number of channels currently high) for the downstream DAC/PWM stage.
module tone_osc_bank
  import tone_pkg::*;
#(
  parameter  int unsigned CLOCK_SPEED = 25_000_000,
  parameter  int unsigned N_CH        = 4,
  parameter  int unsigned CNT_W       = 32,
  localparam int unsigned MIX_W       = $clog2(N_CH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   en_i,
  input  logic [4*N_CH-1:0] tone_i,
  input  logic [2*N_CH-1:0] oct_i,
  output logic [N_CH-1:0]   wave_o,
  output logic [N_CH-1:0]   edge_o,
  output logic [MIX_W-1:0]  mix_o
);

  logic [MIX_W-1:0] mix_q, mix_d;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    tone_osc_ch #(
      .CLOCK_SPEED(CLOCK_SPEED),
      .CNT_W      (CNT_W)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .en_i  (en_i[k]),
      .tone_i(tone_i[4*k +: 4]),
      .oct_i (oct_i[2*k +: 2]),
      .wave_o(wave_o[k]),
      .edge_o(edge_o[k])
    );
  end

  // Popcount of the already-registered waves, so mix lags wave by one cycle.
  always_comb begin
    mix_d = '0;
    for (int k = 0; k < N_CH; k++) mix_d = mix_d + MIX_W'(wave_o[k]);
  end

  always_ff @(posedge clk) begin
    if (rst) mix_q <= '0;
    else     mix_q <= mix_d;
  end

  assign mix_o = mix_q;

endmodule
